// File: rtl/voter_session.sv
// Timed voting session controller: collects at most one yes/no vote per voter,
// closes on all-voted or timeout, then registers a pass/tie/fail verdict.
module voter_session #(
  parameter int unsigned N_VOTERS = 4,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic                busy,
  output logic                done,
  output logic [2:0]          result,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic [N_VOTERS-1:0] voted,
  output logic                timed_out,
  output logic                dup_err
);

  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StVoting, StTally, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    yes_cnt_q, yes_cnt_d;
  logic [CNT_W-1:0]    no_cnt_q, no_cnt_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic                timed_out_q, timed_out_d;
  logic                dup_err_q, dup_err_d;
  logic [2:0]          result_q, result_d;
  logic                done_q, done_d;

  logic [N_VOTERS-1:0] accept;
  logic [N_VOTERS-1:0] dup_hit;
  logic [CNT_W-1:0]    yes_add, no_add;
  logic [CNT_W:0]      yes_x2;
  logic [CNT_W:0]      n_voters_w;

  assign accept     = vote_valid & ~voted_q;
  assign dup_hit    = vote_valid & voted_q;
  // Verdict arithmetic one bit wider than the counters so 2*yes cannot wrap.
  assign yes_x2     = {yes_cnt_q, 1'b0};
  assign n_voters_w = (CNT_W + 1)'(N_VOTERS);

  always_comb begin
    yes_add = '0;
    no_add  = '0;
    for (int i = 0; i < int'(N_VOTERS); i++) begin
      if (accept[i] && vote_yes[i]) yes_add = yes_add + CNT_W'(1);
      if (accept[i] && !vote_yes[i]) no_add = no_add + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    yes_cnt_d   = yes_cnt_q;
    no_cnt_d    = no_cnt_q;
    voted_d     = voted_q;
    timer_d     = timer_q;
    timed_out_d = timed_out_q;
    dup_err_d   = dup_err_q;
    result_d    = result_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StVoting;
          yes_cnt_d   = '0;
          no_cnt_d    = '0;
          voted_d     = '0;
          timer_d     = '0;
          timed_out_d = 1'b0;
          dup_err_d   = 1'b0;
          result_d    = 3'b000;
        end
      end
      StVoting: begin
        voted_d   = voted_q | accept;
        yes_cnt_d = yes_cnt_q + yes_add;
        no_cnt_d  = no_cnt_q + no_add;
        timer_d   = timer_q + TmrW'(1);
        if (|dup_hit) dup_err_d = 1'b1;
        // All-voted takes priority over a timeout landing on the same edge.
        if (&voted_d) begin
          state_d     = StTally;
          timed_out_d = 1'b0;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          state_d     = StTally;
          timed_out_d = 1'b1;
        end
      end
      StTally: begin
        state_d = StDone;
        done_d  = 1'b1;
        if (yes_x2 > n_voters_w) begin
          result_d = 3'b100;
        end else if (yes_x2 == n_voters_w) begin
          result_d = 3'b010;
        end else begin
          result_d = 3'b001;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      yes_cnt_q   <= '0;
      no_cnt_q    <= '0;
      voted_q     <= '0;
      timer_q     <= '0;
      timed_out_q <= 1'b0;
      dup_err_q   <= 1'b0;
      result_q    <= 3'b000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      yes_cnt_q   <= yes_cnt_d;
      no_cnt_q    <= no_cnt_d;
      voted_q     <= voted_d;
      timer_q     <= timer_d;
      timed_out_q <= timed_out_d;
      dup_err_q   <= dup_err_d;
      result_q    <= result_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == StVoting) || (state_q == StTally);
  assign done      = done_q;
  assign result    = result_q;
  assign yes_cnt   = yes_cnt_q;
  assign no_cnt    = no_cnt_q;
  assign voted     = voted_q;
  assign timed_out = timed_out_q;
  assign dup_err   = dup_err_q;

endmodule

// File: tb/tb_voter_session.sv
// Directed bench for voter_session: a 4-voter/8-cycle instance for the main
// session flows and a 7-voter instance for the odd-count verdict corner.
module tb_voter_session;

  logic clk;
  logic rst_n;

  logic       start;
  logic [3:0] vote_valid, vote_yes;
  logic       busy, done, timed_out, dup_err;
  logic [2:0] result;
  logic [2:0] yes_cnt, no_cnt;
  logic [3:0] voted;

  logic       start7;
  logic [6:0] vote_valid7, vote_yes7;
  logic       busy7, done7, timed_out7, dup_err7;
  logic [2:0] result7;
  logic [2:0] yes_cnt7, no_cnt7;
  logic [6:0] voted7;

  int n_checks = 0;
  int n_fail   = 0;

  voter_session #(.N_VOTERS(4), .TIMEOUT(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vote_valid (vote_valid),
    .vote_yes   (vote_yes),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .yes_cnt    (yes_cnt),
    .no_cnt     (no_cnt),
    .voted      (voted),
    .timed_out  (timed_out),
    .dup_err    (dup_err)
  );

  voter_session #(.N_VOTERS(7), .TIMEOUT(8)) u_dut7 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start7),
    .vote_valid (vote_valid7),
    .vote_yes   (vote_yes7),
    .busy       (busy7),
    .done       (done7),
    .result     (result7),
    .yes_cnt    (yes_cnt7),
    .no_cnt     (no_cnt7),
    .voted      (voted7),
    .timed_out  (timed_out7),
    .dup_err    (dup_err7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic [3:0] v, input logic [3:0] y);
    vote_valid = v;
    vote_yes   = y;
    tick();
    vote_valid = '0;
    vote_yes   = '0;
  endtask

  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; vote_valid = '0; vote_yes = '0;
    start7 = 0; vote_valid7 = '0; vote_yes7 = '0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_result", 32'(result), 0);
    check("rst_voted", 32'(voted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1: asynchronous reset mid-session
    open_session();
    vote(4'b0001, 4'b0001);
    vote(4'b0010, 4'b0010);
    check("pre_rst_yes", 32'(yes_cnt), 2);
    rst_n = 1'b0;
    #1;
    check("async_rst_yes", 32'(yes_cnt), 0);
    check("async_rst_voted", 32'(voted), 0);
    check("async_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    #1;

    // 2: majority pass on separate cycles
    open_session();
    check("t2_busy", 32'(busy), 1);
    vote(4'b0001, 4'b0001);
    vote(4'b0010, 4'b0010);
    vote(4'b0100, 4'b0100);
    check("t2_yes_mid", 32'(yes_cnt), 3);
    vote(4'b1000, 4'b0000);
    check("t2_tally_busy", 32'(busy), 1);
    check("t2_tally_done", 32'(done), 0);
    check("t2_tally_result", 32'(result), 0);
    check("t2_counts", 32'({yes_cnt, no_cnt}), 32'({3'd3, 3'd1}));
    tick();
    check("t2_done", 32'(done), 1);
    check("t2_result", 32'(result), 3'b100);
    check("t2_busy_done", 32'(busy), 0);
    check("t2_timed_out", 32'(timed_out), 0);
    tick();
    check("t2_done_pulse", 32'(done), 0);
    check("t2_result_hold", 32'(result), 3'b100);

    // 3: simultaneous tie
    open_session();
    check("t3_cleared", 32'({result, yes_cnt, voted}), 0);
    vote(4'b1111, 4'b0101);
    check("t3_counts", 32'({yes_cnt, no_cnt}), 32'({3'd2, 3'd2}));
    check("t3_not_yet", 32'(result), 0);
    tick();
    check("t3_result", 32'(result), 3'b010);

    // 4a: timeout with a single yes; exactly 8 voting cycles
    open_session();
    vote(4'b0001, 4'b0001);
    for (int i = 0; i < 6; i++) tick();
    check("t4_cycle8_busy", 32'(busy), 1);
    check("t4_cycle8_to", 32'(timed_out), 0);
    tick();
    check("t4_tally_to", 32'(timed_out), 1);
    tick();
    check("t4_result", 32'(result), 3'b001);
    check("t4_voted", 32'(voted), 4'b0001);
    check("t4_done", 32'(done), 1);

    // 4b: vote arriving in the last cycle (timer==7) still counts
    open_session();
    vote(4'b0001, 4'b0001);
    for (int i = 0; i < 6; i++) tick();
    vote(4'b0010, 4'b0010);
    check("t4b_yes", 32'(yes_cnt), 2);
    check("t4b_to", 32'(timed_out), 1);
    tick();
    check("t4b_result", 32'(result), 3'b010);

    // 4c: last cycle completes all votes -> all-voted wins
    open_session();
    vote(4'b0001, 4'b0001);
    for (int i = 0; i < 6; i++) tick();
    vote(4'b1110, 4'b0000);
    check("t4c_to", 32'(timed_out), 0);
    tick();
    check("t4c_result", 32'(result), 3'b001);

    // 5: duplicates discarded, dup_err sticky
    open_session();
    vote(4'b0100, 4'b0100);
    check("t5_dup0", 32'(dup_err), 0);
    vote(4'b0100, 4'b0100);
    check("t5_dup1", 32'(dup_err), 1);
    vote(4'b0100, 4'b0000);
    check("t5_counts", 32'({yes_cnt, no_cnt}), 32'({3'd1, 3'd0}));
    vote(4'b1011, 4'b0000);
    tick();
    check("t5_dup_sticky", 32'(dup_err), 1);
    check("t5_result", 32'(result), 3'b001);

    // 6: votes in start cycle ignored; start during voting ignored
    vote_valid = 4'b1111; vote_yes = 4'b1111;
    open_session();
    vote_valid = '0; vote_yes = '0;
    check("t6_start_clear", 32'({dup_err, voted, yes_cnt}), 0);
    start = 1'b1;
    vote(4'b0001, 4'b0001);
    tick();
    start = 1'b0;
    check("t6_start_ignored", 32'({busy, yes_cnt, voted}), 32'({1'b1, 3'd1, 4'b0001}));
    vote(4'b1110, 4'b0000);
    tick();
    check("t6_result", 32'(result), 3'b001);
    vote(4'b0001, 4'b0001);
    check("t6_done_vote_ign", 32'({dup_err, yes_cnt}), 32'({1'b0, 3'd1}));

    // 6b: seven voters, 4 yes passes, 3 yes fails
    start7 = 1'b1; tick(); start7 = 1'b0;
    vote_valid7 = 7'b0001111; vote_yes7 = 7'b0001111; tick();
    vote_valid7 = 7'b1110000; vote_yes7 = 7'b0000000; tick();
    vote_valid7 = '0; vote_yes7 = '0;
    check("n7_counts_a", 32'({yes_cnt7, no_cnt7}), 32'({3'd4, 3'd3}));
    tick();
    check("n7_pass", 32'(result7), 3'b100);
    start7 = 1'b1; tick(); start7 = 1'b0;
    vote_valid7 = 7'b1111111; vote_yes7 = 7'b0000111; tick();
    vote_valid7 = '0; vote_yes7 = '0;
    check("n7_counts_b", 32'({yes_cnt7, no_cnt7}), 32'({3'd3, 3'd4}));
    tick();
    check("n7_fail", 32'(result7), 3'b001);
    check("n7_done", 32'(done7), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
